ex_stage_pipe: RTL and testbench
================================

// Module: ex_stage_pipe
// PURPOSE
//   ID->EX register, execute stage (ARM-style 32-bit ALU, NZCV status register) and EX->MEM register in one block.
//   Sits between instruction decode and memory access in the 5-stage pipeline.
//   The PC travels alongside its instruction: id_pc -> ex_pc (1 cycle) -> mem_pc (2 cycles).
// PARAMETERS
//   DW  32  datapath/PC width
//   RW  4   register-index width (dest)
// PORTS
//   clk          in   1    rising-edge clock
//   rst          in   1    synchronous reset, active-low (0 = reset)
//   freeze       in   1    hold ID/EX register contents (stall)
//   flush        in   1    load a bubble into ID/EX
//   id_pc        in   DW   PC of the instruction in decode
//   id_exe_cmd   in   4    ALU opcode
//   id_val1      in   DW   operand Rn
//   id_val2      in   DW   operand 2 (already shifted/immediate)
//   id_val_rm    in   DW   store data
//   id_dest      in   RW   writeback register index
//   id_wb_en, id_mem_r, id_mem_w, id_s, id_b   in 1 each: writeback, load, store, set-flags, branch
//   id_imm24     in   24   branch offset
//   ex_pc        out  DW   PC held in ID/EX
//   mem_pc       out  DW   PC held in EX/MEM
//   mem_alu_res  out  DW   ALU result / memory address
//   mem_val_rm   out  DW   store data
//   mem_dest     out  RW   writeback index
//   mem_wb_en, mem_mem_r, mem_mem_w  out 1 each
//   status       out  4    {N,Z,C,V} status register
//   br_taken     out  1    branch taken (combinational, EX stage)
//   br_addr      out  DW   branch target (combinational, EX stage)
// BEHAVIOUR
//   - All registers update on the rising clk edge only. rst==0 at an edge clears every register to 0: ex_*, mem_*, status.
//   - Reset overrides flush/freeze. Between resets, flush has priority over freeze.
//   - ID/EX register:
//     - freeze=1: hold all contents.
//     - flush=1: clear wb_en, mem_r, mem_w, s and b; ex_pc=0; data fields 0.
//     - otherwise: capture all id_* inputs.
//   - EX/MEM register: always captures the execute outputs each cycle, so MEM-side outputs trail ID-side inputs by exactly 2 cycles.
//   - ALU (combinational on ID/EX contents; cin = status C):
//     - 0001 MOV: v2
//     - 1001 MVN: ~v2
//     - 0010 ADD: v1+v2
//     - 0011 ADC: v1+v2+cin
//     - 0100 SUB: v1-v2
//     - 0101 SBC: v1-v2-!cin
//     - 0110 AND: v1&v2
//     - 0111 ORR: v1|v2
//     - 1000 EOR: v1^v2
//     - 1100 CMP: v1-v2
//     - 1110 TST: v1&v2
//     - 1010 LDR/STR address: v1+v2
//     - any other code: result 0, flags unchanged
//   - Flags:
//     - N = res[31]; Z = (res==0).
//     - Arithmetic ops: C = 33rd-bit carry (SUB: C = no borrow); V = signed overflow.
//     - Logical and MOV ops: C and V keep their current value.
//     - status loads the new flags at the clock edge only when the ID/EX s bit is 1; otherwise it holds.
//     - A status update and a following ADC/SBC one cycle later: the later op sees the updated C.
//   - mem_alu_res wraps modulo 2^32; no saturation.
// CONFIGURATION
//   EXE_BRANCH_EN
//     - Defined: br_taken = ID/EX b bit; br_addr = ex_pc + 4 + (sign-extended imm24 << 2), 32-bit wrap.
//     - Undefined: br_taken=0, br_addr=0, imm24 ignored; ports remain.
// TESTING
//   1. Hold rst=0 two edges with nonzero inputs -> ex_pc, mem_pc, mem_* all 0; status=0000.
//   2. After release, id_pc=0,4,8,... one per cycle -> ex_pc lags id_pc 1 cycle; mem_pc lags 2 cycles.
//   3. ADD with s=1, v1=0x7FFFFFFF, v2=1 -> mem_alu_res=0x80000000; status=1001.
//      Then SUB 5-5, s=1 -> res 0, status=0110.
//   4. ADC 1+1 with C=1 -> 3. Repeat with s=0 -> status unchanged.
//   5. freeze=1 for 3 cycles -> ex_pc constant; mem_pc repeats the same value.
//      flush=1 with wb_en=1 -> one bubble in which mem_wb_en=0.
//   6. EXE_BRANCH_EN defined, ex_pc=0x100, imm24=0xFFFFFE, b=1 -> br_taken=1, br_addr=0xFC.

Source files
------------

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: ID/EX pipeline register, 32-bit ARM-style ALU with an NZCV
// status register, and the EX/MEM pipeline register.
// The PC travels with its instruction: id_pc -> ex_pc -> mem_pc.
// Optional feature macro: EXE_BRANCH_EN enables branch-target generation.
// Without it, br_taken and br_addr are tied to 0 and id_imm24 is ignored.
module ex_stage_pipe #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          flush,
  input  logic [DW-1:0] id_pc,
  input  logic [3:0]    id_exe_cmd,
  input  logic [DW-1:0] id_val1,
  input  logic [DW-1:0] id_val2,
  input  logic [DW-1:0] id_val_rm,
  input  logic [RW-1:0] id_dest,
  input  logic          id_wb_en,
  input  logic          id_mem_r,
  input  logic          id_mem_w,
  input  logic          id_s,
  input  logic          id_b,
  input  logic [23:0]   id_imm24,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] mem_pc,
  output logic [DW-1:0] mem_alu_res,
  output logic [DW-1:0] mem_val_rm,
  output logic [RW-1:0] mem_dest,
  output logic          mem_wb_en,
  output logic          mem_mem_r,
  output logic          mem_mem_w,
  output logic [3:0]    status,
  output logic          br_taken,
  output logic [DW-1:0] br_addr
);

  // Signed overflow of a + b: operands agree in sign, result disagrees.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    add_ovf = (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of a - b: operands differ in sign, result disagrees with a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    sub_ovf = (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  // ID/EX contents
  logic [DW-1:0] ex_pc_r;
  logic [3:0]    cmd_r;
  logic [DW-1:0] v1_r;
  logic [DW-1:0] v2_r;
  logic [DW-1:0] vrm_r;
  logic [RW-1:0] dest_r;
  logic          wb_en_r;
  logic          mem_r_r;
  logic          mem_w_r;
  logic          s_r;
  logic          b_r;
  logic [23:0]   imm24_r;

  // EX/MEM contents and status
  logic [DW-1:0] mem_pc_r;
  logic [DW-1:0] mem_res_r;
  logic [DW-1:0] mem_vrm_r;
  logic [RW-1:0] mem_dest_r;
  logic          mem_wb_en_r;
  logic          mem_mem_r_r;
  logic          mem_mem_w_r;
  logic [3:0]    status_r;

  // ALU outputs
  logic [DW:0]   sum_s;
  logic [DW-1:0] res_s;
  logic          c_s;
  logic          v_s;
  logic          flags_ok_s;
  logic [3:0]    flags_s;

  // ID/EX register: reset and flush load a bubble, freeze holds, else capture
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      ex_pc_r <= {DW{1'b0}};
      cmd_r   <= 4'd0;
      v1_r    <= {DW{1'b0}};
      v2_r    <= {DW{1'b0}};
      vrm_r   <= {DW{1'b0}};
      dest_r  <= {RW{1'b0}};
      wb_en_r <= 1'b0;
      mem_r_r <= 1'b0;
      mem_w_r <= 1'b0;
      s_r     <= 1'b0;
      b_r     <= 1'b0;
      imm24_r <= 24'd0;
    end else if (!freeze) begin
      ex_pc_r <= id_pc;
      cmd_r   <= id_exe_cmd;
      v1_r    <= id_val1;
      v2_r    <= id_val2;
      vrm_r   <= id_val_rm;
      dest_r  <= id_dest;
      wb_en_r <= id_wb_en;
      mem_r_r <= id_mem_r;
      mem_w_r <= id_mem_w;
      s_r     <= id_s;
      b_r     <= id_b;
      imm24_r <= id_imm24;
    end
  end

  // ALU: result plus C/V; logical ops keep C/V, unknown opcodes leave flags alone
  always_comb begin
    sum_s      = {(DW + 1){1'b0}};
    res_s      = {DW{1'b0}};
    c_s        = status_r[1];
    v_s        = status_r[0];
    flags_ok_s = 1'b1;
    case (cmd_r)
      4'b0001: res_s = v2_r;
      4'b1001: res_s = ~v2_r;
      4'b0010, 4'b1010: begin
        sum_s = {1'b0, v1_r} + {1'b0, v2_r};
        res_s = sum_s[DW-1:0];
        c_s   = sum_s[DW];
        v_s   = add_ovf(v1_r[DW-1], v2_r[DW-1], sum_s[DW-1]);
      end
      4'b0011: begin
        sum_s = {1'b0, v1_r} + {1'b0, v2_r} + {{DW{1'b0}}, status_r[1]};
        res_s = sum_s[DW-1:0];
        c_s   = sum_s[DW];
        v_s   = add_ovf(v1_r[DW-1], v2_r[DW-1], sum_s[DW-1]);
      end
      4'b0100, 4'b1100: begin
        // subtraction as a + ~b + 1 so carry-out means "no borrow"
        sum_s = {1'b0, v1_r} + {1'b0, ~v2_r} + {{DW{1'b0}}, 1'b1};
        res_s = sum_s[DW-1:0];
        c_s   = sum_s[DW];
        v_s   = sub_ovf(v1_r[DW-1], v2_r[DW-1], sum_s[DW-1]);
      end
      4'b0101: begin
        // a - b - !cin == a + ~b + cin
        sum_s = {1'b0, v1_r} + {1'b0, ~v2_r} + {{DW{1'b0}}, status_r[1]};
        res_s = sum_s[DW-1:0];
        c_s   = sum_s[DW];
        v_s   = sub_ovf(v1_r[DW-1], v2_r[DW-1], sum_s[DW-1]);
      end
      4'b0110, 4'b1110: res_s = v1_r & v2_r;
      4'b0111: res_s = v1_r | v2_r;
      4'b1000: res_s = v1_r ^ v2_r;
      default: begin
        res_s      = {DW{1'b0}};
        flags_ok_s = 1'b0;
      end
    endcase
    flags_s = {res_s[DW-1], (res_s == {DW{1'b0}}), c_s, v_s};
  end

  // EX/MEM register: captures the execute outputs every cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_pc_r    <= {DW{1'b0}};
      mem_res_r   <= {DW{1'b0}};
      mem_vrm_r   <= {DW{1'b0}};
      mem_dest_r  <= {RW{1'b0}};
      mem_wb_en_r <= 1'b0;
      mem_mem_r_r <= 1'b0;
      mem_mem_w_r <= 1'b0;
    end else begin
      mem_pc_r    <= ex_pc_r;
      mem_res_r   <= res_s;
      mem_vrm_r   <= vrm_r;
      mem_dest_r  <= dest_r;
      mem_wb_en_r <= wb_en_r;
      mem_mem_r_r <= mem_r_r;
      mem_mem_w_r <= mem_w_r;
    end
  end

  // Status register: loads new NZCV only for flag-setting, recognised ops
  always_ff @(posedge clk) begin
    if (!rst) begin
      status_r <= 4'b0000;
    end else if (s_r && flags_ok_s) begin
      status_r <= flags_s;
    end
  end

  assign ex_pc       = ex_pc_r;
  assign mem_pc      = mem_pc_r;
  assign mem_alu_res = mem_res_r;
  assign mem_val_rm  = mem_vrm_r;
  assign mem_dest    = mem_dest_r;
  assign mem_wb_en   = mem_wb_en_r;
  assign mem_mem_r   = mem_mem_r_r;
  assign mem_mem_w   = mem_mem_w_r;
  assign status      = status_r;

`ifdef EXE_BRANCH_EN
  // branch target: PC + 4 + sign-extended word offset, wrapping at DW bits
  assign br_taken = b_r;
  assign br_addr  = ex_pc_r + {{(DW - 3){1'b0}}, 3'd4} + {{(DW - 26){imm24_r[23]}}, imm24_r, 2'b00};
`else
  // branch path absent: the b bit and offset are carried but not consumed
  logic unused_branch_s;
  assign unused_branch_s = ^{b_r, imm24_r};
  assign br_taken = 1'b0;
  assign br_addr  = {DW{1'b0}};
`endif

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe: directed steps followed by random
// traffic, checked against a behavioural reference model of the stage.
module tb_ex_stage_pipe;
  localparam int DW = 32;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst, freeze, flush;
  logic [DW-1:0] id_pc, id_val1, id_val2, id_val_rm;
  logic [3:0]    id_exe_cmd;
  logic [RW-1:0] id_dest;
  logic          id_wb_en, id_mem_r, id_mem_w, id_s, id_b;
  logic [23:0]   id_imm24;
  logic [DW-1:0] ex_pc, mem_pc, mem_alu_res, mem_val_rm, br_addr;
  logic [RW-1:0] mem_dest;
  logic          mem_wb_en, mem_mem_r, mem_mem_w, br_taken;
  logic [3:0]    status;

  ex_stage_pipe #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_pc(id_pc), .id_exe_cmd(id_exe_cmd), .id_val1(id_val1), .id_val2(id_val2),
    .id_val_rm(id_val_rm), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r(id_mem_r),
    .id_mem_w(id_mem_w), .id_s(id_s), .id_b(id_b), .id_imm24(id_imm24),
    .ex_pc(ex_pc), .mem_pc(mem_pc), .mem_alu_res(mem_alu_res), .mem_val_rm(mem_val_rm),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_mem_r(mem_mem_r), .mem_mem_w(mem_mem_w),
    .status(status), .br_taken(br_taken), .br_addr(br_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model: instruction sitting in EX, instruction sitting in MEM, flags
  logic [31:0] m_pc, m_v1, m_v2, m_vrm;
  logic [3:0]  m_cmd, m_dest;
  logic        m_wb, m_mr, m_mw, m_s, m_b;
  logic [23:0] m_imm;
  logic [31:0] mm_pc, mm_res, mm_vrm;
  logic [3:0]  mm_dest;
  logic        mm_wb, mm_mr, mm_mw;
  logic [3:0]  m_status;

  logic [31:0] edge_vals [5] = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ALU semantics from plain wide integer arithmetic
  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] st, output logic [31:0] res,
                                  output logic [3:0] nst, output bit ok);
    longint ua, ub, sa, sb, u, s;
    logic c, v, cin;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    cin = st[1]; c = st[1]; v = st[0]; ok = 1'b1; u = 0; s = 0;
    case (cmd)
      4'b0001: res = b;
      4'b1001: res = ~b;
      4'b0010, 4'b1010, 4'b0011: begin
        u = ua + ub + ((cmd == 4'b0011) ? longint'(cin) : 0);
        s = sa + sb + ((cmd == 4'b0011) ? longint'(cin) : 0);
        res = u[31:0]; c = (u > 64'sh0_FFFF_FFFF);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0100, 4'b1100, 4'b0101: begin
        u = ub + ((cmd == 4'b0101) ? longint'(!cin) : 0);
        s = sa - sb - ((cmd == 4'b0101) ? longint'(!cin) : 0);
        c = (ua >= u);
        u = ua - u;
        res = u[31:0];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110, 4'b1110: res = a & b;
      4'b0111: res = a | b;
      4'b1000: res = a ^ b;
      default: begin res = 32'h0; ok = 1'b0; end
    endcase
    nst = {res[31], (res == 32'h0), c, v};
  endfunction

  task automatic check_all();
    int off;
    logic [31:0] exp_addr;
    off = $signed(m_imm);
    chk("ex_pc", ex_pc, m_pc);
    chk("mem_pc", mem_pc, mm_pc);
    chk("mem_alu_res", mem_alu_res, mm_res);
    chk("mem_val_rm", mem_val_rm, mm_vrm);
    chk("mem_dest", 32'(mem_dest), 32'(mm_dest));
    chk("mem_ctl", {29'd0, mem_wb_en, mem_mem_r, mem_mem_w}, {29'd0, mm_wb, mm_mr, mm_mw});
    chk("status", 32'(status), 32'(m_status));
`ifdef EXE_BRANCH_EN
    exp_addr = m_pc + 32'd4 + 32'(off * 4);
    chk("br_taken", 32'(br_taken), 32'(m_b));
    chk("br_addr", br_addr, exp_addr);
`else
    exp_addr = 32'(off) & 32'h0;
    chk("br_taken", 32'(br_taken), 32'h0);
    chk("br_addr", br_addr, exp_addr);
`endif
  endtask

  // one clock edge: advance the model with the current inputs, then compare
  task automatic tick();
    logic [31:0] r;
    logic [3:0]  ns;
    bit          ok;
    @(posedge clk);
    ref_alu(m_cmd, m_v1, m_v2, m_status, r, ns, ok);
    if (!rst) begin
      {m_pc, m_v1, m_v2, m_vrm, m_cmd, m_dest, m_wb, m_mr, m_mw, m_s, m_b, m_imm} = '0;
      {mm_pc, mm_res, mm_vrm, mm_dest, mm_wb, mm_mr, mm_mw} = '0;
      m_status = 4'b0000;
    end else begin
      mm_pc = m_pc; mm_res = r; mm_vrm = m_vrm; mm_dest = m_dest;
      mm_wb = m_wb; mm_mr = m_mr; mm_mw = m_mw;
      if (m_s && ok) m_status = ns;
      if (flush) begin
        {m_pc, m_v1, m_v2, m_vrm, m_cmd, m_dest, m_wb, m_mr, m_mw, m_s, m_b, m_imm} = '0;
      end else if (!freeze) begin
        m_pc = id_pc; m_v1 = id_val1; m_v2 = id_val2; m_vrm = id_val_rm; m_cmd = id_exe_cmd;
        m_dest = id_dest; m_wb = id_wb_en; m_mr = id_mem_r; m_mw = id_mem_w;
        m_s = id_s; m_b = id_b; m_imm = id_imm24;
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic [31:0] pc, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic s, input logic wb);
    id_pc = pc; id_exe_cmd = cmd; id_val1 = a; id_val2 = b; id_s = s; id_wb_en = wb;
    id_val_rm = 32'h0; id_dest = 4'd1; id_mem_r = 1'b0; id_mem_w = 1'b0; id_b = 1'b0; id_imm24 = 24'd0;
  endtask

  initial begin
    // reset held for two edges with busy inputs
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    drive(32'hDEAD_BEE0, 4'b0010, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
    id_mem_r = 1'b1; id_mem_w = 1'b1; id_b = 1'b1; id_val_rm = 32'h5555_AAAA; id_imm24 = 24'h00_0010;
    tick(); tick();
    chk("rst_ex_pc", ex_pc, 32'h0);
    chk("rst_mem_pc", mem_pc, 32'h0);
    chk("rst_status", 32'(status), 32'h0);
    chk("rst_mem_wb", 32'(mem_wb_en), 32'h0);

    // PC pipeline lag
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(32'(k * 4), 4'b0001, 32'h0, 32'(k), 1'b0, 1'b1);
      tick();
      chk("ex_pc_lag", ex_pc, 32'(k * 4));
      if (k >= 1) chk("mem_pc_lag", mem_pc, 32'((k - 1) * 4));
    end

    // ADD overflow, SUB to zero, ADC seeing fresh carry, ADC with s=1
    drive(32'h40, 4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b1); tick();
    drive(32'h44, 4'b0100, 32'd5, 32'd5, 1'b1, 1'b1); tick();
    chk("add_res", mem_alu_res, 32'h8000_0000);
    chk("add_status", 32'(status), 32'h9);
    drive(32'h48, 4'b0011, 32'd1, 32'd1, 1'b0, 1'b1); tick();
    chk("sub_res", mem_alu_res, 32'h0);
    chk("sub_status", 32'(status), 32'h6);
    drive(32'h4C, 4'b0011, 32'd1, 32'd1, 1'b1, 1'b1); tick();
    chk("adc_res", mem_alu_res, 32'd3);
    chk("adc_s0_status", 32'(status), 32'h6);
    drive(32'h50, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0); tick();
    chk("adc2_res", mem_alu_res, 32'd3);
    chk("adc_s1_status", 32'(status), 32'h0);

    // freeze for three cycles, then flush (taking priority over freeze)
    drive(32'h200, 4'b0001, 32'h0, 32'h77, 1'b0, 1'b1); tick();
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(32'h300 + 32'(k * 4), 4'b0001, 32'h0, 32'h88, 1'b0, 1'b1);
      tick();
      chk("freeze_ex_pc", ex_pc, 32'h200);
      chk("freeze_mem_pc", mem_pc, 32'h200);
    end
    flush = 1'b1; tick();
    flush = 1'b0; freeze = 1'b0; tick();
    chk("flush_bubble_wb", 32'(mem_wb_en), 32'h0);

`ifdef EXE_BRANCH_EN
    drive(32'h100, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
    id_b = 1'b1; id_imm24 = 24'hFF_FFFE; tick();
    chk("br_taken_dir", 32'(br_taken), 32'h1);
    chk("br_addr_dir", br_addr, 32'h0000_00FC);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 60) != 0);
      flush = ($urandom_range(0, 9) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      id_pc = $urandom; id_exe_cmd = 4'($urandom_range(0, 15));
      id_val1 = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      id_val2 = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      id_val_rm = $urandom; id_dest = 4'($urandom_range(0, 15));
      id_wb_en = 1'($urandom); id_mem_r = 1'($urandom); id_mem_w = 1'($urandom);
      id_s = 1'($urandom); id_b = 1'($urandom); id_imm24 = 24'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
